// File: rtl/lcd_text_fifo_pkg.sv
// Shared types and constants for the USB-to-HD44780 text path.
package lcd_text_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_NIB2,
    ST_WAIT,
    ST_INIT
  } lcd_state_e;

  localparam logic [7:0] ESC_BYTE   = 8'h00;
  localparam logic [7:0] CMD_CLEAR  = 8'h01;
  localparam logic [7:0] CMD_HOME   = 8'h02;
  localparam logic [7:0] FUNC_SET_8 = 8'h38;
  localparam logic [7:0] FUNC_SET_4 = 8'h28;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] ENTRY_INC  = 8'h06;

  // One LCD write: single = only the high nibble is sent (4-bit bus wake-up).
  typedef struct packed {
    logic       single;
    logic       slow;
    logic [7:0] data;
  } lcd_cmd_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear/home (0x01..0x03 decode) need the long busy wait.
  function automatic logic is_slow(input logic rs, input logic [7:0] b);
    return !rs && (b == CMD_CLEAR || b == CMD_HOME || b == 8'h03);
  endfunction

  // Power-up command list; 4-bit mode starts with the 3/3/3/2 nibble dance.
  function automatic lcd_cmd_t init_cmd(input logic bus4, input logic [2:0] idx);
    lcd_cmd_t c;
    c.single = 1'b0;
    c.slow   = 1'b0;
    c.data   = ENTRY_INC;
    if (bus4) begin
      case (idx)
        3'd0, 3'd1, 3'd2: begin c.single = 1'b1; c.data = 8'h30; end
        3'd3:             begin c.single = 1'b1; c.data = 8'h20; end
        3'd4:             c.data = FUNC_SET_4;
        3'd5:             c.data = DISP_ON;
        3'd6:             c.data = CMD_CLEAR;
        default:          c.data = ENTRY_INC;
      endcase
    end else begin
      case (idx)
        3'd0:    c.data = FUNC_SET_8;
        3'd1:    c.data = DISP_ON;
        3'd2:    c.data = CMD_CLEAR;
        default: c.data = ENTRY_INC;
      endcase
    end
    c.slow = c.single ? (c.data == 8'h30) : is_slow(1'b0, c.data);
    return c;
  endfunction

endpackage

// File: rtl/lcd_text_fifo_if.sv
// USB byte input and HD44780 output pins of the text FIFO.
interface lcd_text_fifo_if;
  logic       USB_FWRn;
  logic [7:0] USB_D;
  logic       FIFO_FULL;
  logic       OVERFLOW;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;
  logic [7:0] LCD_DB;

  modport master (output USB_FWRn, USB_D,
                  input  FIFO_FULL, OVERFLOW, LCD_RS, LCD_RW, LCD_E, LCD_DB);
  modport slave  (input  USB_FWRn, USB_D,
                  output FIFO_FULL, OVERFLOW, LCD_RS, LCD_RW, LCD_E, LCD_DB);
endinterface

// File: rtl/lcd_text_fifo_sync_fifo.sv
// First-word-fall-through FIFO; pushes when full and pops when empty are ignored.
module lcd_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign dout  = mem_q[rd_ptr_q];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    cnt_d    = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end

  // Pointer/count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/lcd_text_fifo.sv
// USB byte stream -> escape decode -> FIFO -> timed HD44780 write engine.
// Optional build macro LCD_INIT_SEQ_EN adds a power-up delay and LCD init sequence.
module lcd_text_fifo
  import lcd_text_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter bit          BUS_4BIT       = 1'b0,
  parameter int unsigned SETUP_CLKS     = 2,
  parameter int unsigned E_PULSE_CLKS   = 6,
  parameter int unsigned CMD_WAIT_CLKS  = 1032,
  parameter int unsigned SLOW_WAIT_CLKS = 39360,
  parameter int unsigned POWERUP_CLKS   = 360000
) (
  input logic            CLK_USB,
  input logic            RSTn,
  lcd_text_fifo_if.slave bus
);
`ifdef LCD_INIT_SEQ_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  localparam int unsigned WAIT_MAX = max2(max2(CMD_WAIT_CLKS, SLOW_WAIT_CLKS),
                                          max2(SETUP_CLKS, E_PULSE_CLKS));
  localparam int unsigned CNT_MAX  = INIT_EN ? max2(WAIT_MAX, POWERUP_CLKS) : WAIT_MAX;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CLKS - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(E_PULSE_CLKS - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CLKS - 1);
  localparam logic [CNT_W-1:0] SLOW_LD  = CNT_W'(SLOW_WAIT_CLKS - 1);
  localparam logic [CNT_W-1:0] RST_CNT  = INIT_EN ? CNT_W'(POWERUP_CLKS - 1) : '0;
  localparam lcd_state_e       RST_ST   = INIT_EN ? ST_INIT : ST_IDLE;

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d, rs_q, rs_d, slow_q, slow_d, single_q, single_d;
  logic             nib_lo_q, nib_lo_d, esc_q, esc_d, ovf_q, ovf_d;
  logic [7:0]       db_q, db_d, byte_q, byte_d;
  logic             push, pop, fifo_full, fifo_empty, ld, ld_rs;
  logic [8:0]       push_din, fifo_dout;
  lcd_cmd_t         ld_cmd;

  lcd_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
    .clk(CLK_USB), .rst_n(RSTn), .push(push), .din(push_din),
    .pop(pop), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );

  assign bus.FIFO_FULL = fifo_full;
  assign bus.OVERFLOW  = ovf_q;
  assign bus.LCD_RS    = rs_q;
  assign bus.LCD_RW    = 1'b0;
  assign bus.LCD_E     = e_q;
  assign bus.LCD_DB    = db_q;

  // Write side: a lone 0x00 arms the escape, the next byte becomes a command.
  always_comb begin
    push     = 1'b0;
    push_din = {1'b1, bus.USB_D};
    esc_d    = esc_q;
    ovf_d    = ovf_q;
    if (!bus.USB_FWRn) begin
      if (!esc_q && bus.USB_D == ESC_BYTE) begin
        esc_d = 1'b1;
      end else begin
        push     = 1'b1;
        push_din = {~esc_q, bus.USB_D};
        esc_d    = 1'b0;
        if (fifo_full) ovf_d = 1'b1;
      end
    end
  end

`ifdef LCD_INIT_SEQ_EN
  localparam logic [3:0] INIT_LEN = BUS_4BIT ? 4'd8 : 4'd4;
  logic [3:0] init_idx_q, init_idx_d;

  // Init command index; advances each time IDLE issues an init write.
  always_ff @(posedge CLK_USB or negedge RSTn) begin
    if (!RSTn) init_idx_q <= '0;
    else       init_idx_q <= init_idx_d;
  end
`endif

  // Write engine next state: load a byte, setup, E pulse, hold, optional second nibble, busy wait.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    e_d      = e_q;
    rs_d     = rs_q;
    db_d     = db_q;
    byte_d   = byte_q;
    slow_d   = slow_q;
    single_d = single_q;
    nib_lo_d = nib_lo_q;
    pop      = 1'b0;
    ld       = 1'b0;
    ld_rs    = 1'b1;
    ld_cmd   = '0;
`ifdef LCD_INIT_SEQ_EN
    init_idx_d = init_idx_q;
`endif
    case (state_q)
      ST_INIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_IDLE: begin
`ifdef LCD_INIT_SEQ_EN
        if (init_idx_q != INIT_LEN) begin
          ld         = 1'b1;
          ld_rs      = 1'b0;
          ld_cmd     = init_cmd(BUS_4BIT, init_idx_q[2:0]);
          init_idx_d = init_idx_q + 4'd1;
        end else
`endif
        if (!fifo_empty) begin
          ld          = 1'b1;
          pop         = 1'b1;
          ld_rs       = fifo_dout[8];
          ld_cmd.data = fifo_dout[7:0];
          ld_cmd.slow = is_slow(fifo_dout[8], fifo_dout[7:0]);
        end
        if (ld) begin
          rs_d     = ld_rs;
          byte_d   = ld_cmd.data;
          slow_d   = ld_cmd.slow;
          single_d = ld_cmd.single;
          nib_lo_d = 1'b0;
          db_d     = BUS_4BIT ? {ld_cmd.data[7:4], 4'h0} : ld_cmd.data;
          cnt_d    = SETUP_LD;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          e_d     = 1'b1;
          cnt_d   = PULSE_LD;
          state_d = ST_PULSE;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          e_d     = 1'b0;
          state_d = ST_HOLD;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_HOLD: begin
        if (BUS_4BIT && !single_q && !nib_lo_q) begin
          state_d = ST_NIB2;
        end else begin
          cnt_d   = slow_q ? SLOW_LD : CMD_LD;
          state_d = ST_WAIT;
        end
      end
      ST_NIB2: begin
        db_d     = {byte_q[3:0], 4'h0};
        nib_lo_d = 1'b1;
        cnt_d    = SETUP_LD;
        state_d  = ST_SETUP;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All engine/outputs registered; async reset drops LCD_E immediately.
  always_ff @(posedge CLK_USB or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= RST_ST;
      cnt_q    <= RST_CNT;
      e_q      <= 1'b0;
      rs_q     <= 1'b0;
      db_q     <= '0;
      byte_q   <= '0;
      slow_q   <= 1'b0;
      single_q <= 1'b0;
      nib_lo_q <= 1'b0;
      esc_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      e_q      <= e_d;
      rs_q     <= rs_d;
      db_q     <= db_d;
      byte_q   <= byte_d;
      slow_q   <= slow_d;
      single_q <= single_d;
      nib_lo_q <= nib_lo_d;
      esc_q    <= esc_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_lcd_text_fifo.sv
// Directed bench: 8-bit instance for data/escape/overflow/reset, 4-bit instance for nibble order.
module tb_lcd_text_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_text_fifo_if bus ();
  lcd_text_fifo_if bus4 ();

  lcd_text_fifo dut (.CLK_USB(clk), .RSTn(rst_n), .bus(bus));
  lcd_text_fifo #(.BUS_4BIT(1'b1)) dut4 (.CLK_USB(clk), .RSTn(rst_n), .bus(bus4));

  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         rise;
    int         fall;
  } pulse_t;

  pulse_t q[$];
  pulse_t q4[$];
  pulse_t cur, cur4;
  logic   e_prev = 1'b0, e4_prev = 1'b0;

  // Record every LCD_E pulse (edge numbers of rise and fall, RS/DB at rise).
  always @(negedge clk) begin
    if (bus.LCD_E && !e_prev) begin cur.rise = cyc; cur.rs = bus.LCD_RS; cur.db = bus.LCD_DB; end
    if (!bus.LCD_E && e_prev) begin cur.fall = cyc; q.push_back(cur); end
    e_prev = bus.LCD_E;
    if (bus4.LCD_E && !e4_prev) begin cur4.rise = cyc; cur4.rs = bus4.LCD_RS; cur4.db = bus4.LCD_DB; end
    if (!bus4.LCD_E && e4_prev) begin cur4.fall = cyc; q4.push_back(cur4); end
    e4_prev = bus4.LCD_E;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_q(input int n, input int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin @(negedge clk); k++; end
    checks++;
    if (q.size() < n) begin
      failures++;
      $display("FAIL wait_pulse: got %0d pulses expected %0d within %0d clocks", q.size(), n, budget);
    end
  endtask

  // Push one byte (preceded by the escape 0x00 if esc); e = edge that samples b.
  task automatic push(input bit esc, input logic [7:0] b, output int e);
    @(negedge clk);
    bus.USB_FWRn = 1'b0;
    if (esc) begin bus.USB_D = 8'h00; @(negedge clk); end
    bus.USB_D = b;
    e = cyc + 1;
    @(negedge clk);
    bus.USB_FWRn = 1'b1;
  endtask

  typedef struct {
    bit         esc;
    logic [7:0] b;
    logic       rs;
    logic [7:0] db;
    int         w;
  } vec_t;

  vec_t vt[5];

  initial begin
    int pe;
    int base;
    int k;
    vt[0] = '{1'b0, 8'h41, 1'b1, 8'h41, 1032};
    vt[1] = '{1'b1, 8'h01, 1'b0, 8'h01, 39360};
    vt[2] = '{1'b1, 8'h38, 1'b0, 8'h38, 1032};
    vt[3] = '{1'b1, 8'h00, 1'b0, 8'h00, 1032};
    vt[4] = '{1'b1, 8'h04, 1'b0, 8'h04, 1032};

    bus.USB_FWRn = 1'b1;  bus.USB_D = 8'h00;
    bus4.USB_FWRn = 1'b1; bus4.USB_D = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_e", bus.LCD_E, 0);
    chk("rst_rs", bus.LCD_RS, 0);
    chk("rst_db", bus.LCD_DB, 0);
    chk("rst_full", bus.FIFO_FULL, 0);
    chk("rst_ovf", bus.OVERFLOW, 0);
    chk("rst_rw", bus.LCD_RW, 0);
    chk("rst4_e", bus4.LCD_E, 0);
    rst_n = 1'b1;

    // 4-bit instance runs alongside; checked later.
    @(negedge clk); bus4.USB_FWRn = 1'b0; bus4.USB_D = 8'h48;
    @(negedge clk); bus4.USB_FWRn = 1'b1;

    // Single-byte vectors, each pushed while the previous write is in its busy wait.
    for (int i = 0; i < 5; i++) begin
      push(vt[i].esc, vt[i].b, pe);
      wait_q(i + 1, (i == 0) ? 100 : vt[i-1].w + 100);
      if (q.size() > i) begin
        chk($sformatf("vec%0d_rs", i), q[i].rs, vt[i].rs);
        chk($sformatf("vec%0d_db", i), q[i].db, vt[i].db);
        if (i == 0) begin
          chk("vec0_rise_latency", q[0].rise - pe, 3);
          chk("vec0_e_width", q[0].fall - q[0].rise, 6);
        end else begin
          chk_range($sformatf("vec%0d_gap", i), q[i].rise - q[i-1].fall, vt[i-1].w, vt[i-1].w + 8);
        end
      end
    end
    chk("rw_tied", bus.LCD_RW, 0);
    repeat (1100) @(negedge clk);

    // 4-bit: 0x48 -> high nibble 0x40, then low nibble 0x80.
    chk("b4_count", q4.size(), 2);
    if (q4.size() >= 2) begin
      chk("b4_rs0", q4[0].rs, 1);
      chk("b4_db0", q4[0].db, 8'h40);
      chk("b4_rs1", q4[1].rs, 1);
      chk("b4_db1", q4[1].db, 8'h80);
    end

    // Overflow: 20 back-to-back bytes into a 16-deep FIFO.
    chk("ovf_pre", bus.OVERFLOW, 0);
    base = q.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 16) chk("full_after_t15", bus.FIFO_FULL, 0);
      if (i == 17) chk("full_after_t16", bus.FIFO_FULL, 1);
      bus.USB_FWRn = 1'b0;
      bus.USB_D = 8'(8'h30 + i);
    end
    @(negedge clk);
    bus.USB_FWRn = 1'b1;
    chk("full_end", bus.FIFO_FULL, 1);
    chk("ovf_set", bus.OVERFLOW, 1);
    wait_q(base + 17, 17 * 1100);
    repeat (1200) @(negedge clk);
    chk("ovf_drained", q.size() - base, 17);
    for (int i = 0; i < 17; i++) begin
      if (base + i < q.size()) begin
        chk($sformatf("ovf%0d_rs", i), q[base+i].rs, 1);
        chk($sformatf("ovf%0d_db", i), q[base+i].db, 8'(8'h30 + i));
      end
    end
    chk("ovf_sticky", bus.OVERFLOW, 1);

    // Reset during an E pulse.
    push(1'b0, 8'h41, pe);
    k = 0;
    while (!bus.LCD_E && k < 20) begin @(negedge clk); k++; end
    chk("mid_pulse_e", bus.LCD_E, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_e", bus.LCD_E, 0);
    chk("async_rst_rs", bus.LCD_RS, 0);
    chk("async_rst_db", bus.LCD_DB, 0);
    chk("async_rst_ovf", bus.OVERFLOW, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    q.delete();
    repeat (60) @(negedge clk);
    chk("post_rst_no_pulse", q.size(), 0);
    push(1'b0, 8'h55, pe);
    wait_q(1, 100);
    if (q.size() >= 1) begin
      chk("post_rst_db", q[0].db, 8'h55);
      chk("post_rst_latency", q[0].rise - pe, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
